// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: binary-angle constants, gain, datapath guard
// width and the vectoring controller state encoding.
package cordic_pkg;

   localparam int unsigned ANGLE_W_DEF = 16;

   // Binary angles for a 16-bit full circle
   localparam logic [15:0] ANG_90  = 16'h4000;
   localparam logic [15:0] ANG_180 = 16'h8000;
   localparam logic [15:0] ANG_270 = 16'hC000;

   // CORDIC gain K (~1.64676) as unsigned Q1.15; compensation is left to consumers
   localparam logic [15:0] CORDIC_GAIN_Q15 = 16'hD2C9;

   // Fractional bits carried below the integer LSB so shift truncation
   // does not leave a stuck residual y that biases the accumulated angle
   localparam int unsigned GUARD_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_DONE
   } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent table: entry i = round(atan(2^-i) * 2^ANGLE_W / (2*pi)).
// Shared by the rotation- and vectoring-mode CORDIC datapaths.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int unsigned ANGLE_W = ANGLE_W_DEF,
   parameter int unsigned IDX_W   = 5
) (
   input  logic [IDX_W-1:0]   i_idx,
   output logic [ANGLE_W-1:0] o_atan
);

   logic [15:0] w_atan16;

   // Table lookup in 16-bit binary-angle units
   always_comb begin
      w_atan16 = '0;
      case (int'(i_idx))
         0:  w_atan16 = 16'h2000;
         1:  w_atan16 = 16'h12E4;
         2:  w_atan16 = 16'h09FB;
         3:  w_atan16 = 16'h0511;
         4:  w_atan16 = 16'h028B;
         5:  w_atan16 = 16'h0146;
         6:  w_atan16 = 16'h00A3;
         7:  w_atan16 = 16'h0051;
         8:  w_atan16 = 16'h0029;
         9:  w_atan16 = 16'h0014;
         10: w_atan16 = 16'h000A;
         11: w_atan16 = 16'h0005;
         12: w_atan16 = 16'h0003;
         13: w_atan16 = 16'h0001;
         14: w_atan16 = 16'h0001;
         default: w_atan16 = '0;
      endcase
   end

   // Rescale to the configured angle width
   if (ANGLE_W >= 16) begin : g_up
      assign o_atan = ANGLE_W'(w_atan16) << (ANGLE_W - 16);
   end else begin : g_dn
      assign o_atan = ANGLE_W'(w_atan16 >> (16 - ANGLE_W));
   end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: drives y to zero one micro-rotation per
// clock, accumulating the binary angle in z and the gain-scaled magnitude in x.
module cordic_vectoring_iter
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned ANGLE_W = ANGLE_W_DEF,
   parameter int unsigned ITER    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH+1:0]        mag_out,
   output logic [ANGLE_W-1:0]      angle_out
);

   // Integer part keeps two headroom bits so -2^(WIDTH-1) negates and the
   // K-scaled magnitude of the extreme corner still fits
   localparam int unsigned DW = WIDTH + 2 + GUARD_BITS;
   localparam int unsigned CW = $clog2(ITER + 1);
   localparam logic [ANGLE_W-1:0] ANG_HALF = {1'b1, {(ANGLE_W-1){1'b0}}};
   localparam logic signed [DW-1:0] HALF_LSB = DW'(1) << (GUARD_BITS - 1);

   state_t r_state, w_state_nxt;

   logic signed [DW-1:0] r_x, r_y;
   logic signed [DW-1:0] w_x_ext, w_y_ext, w_x_shr, w_y_shr, w_mag_rnd;
   logic [ANGLE_W-1:0]   r_z, w_atan, r_angle;
   logic [CW-1:0]        r_iter;
   logic                 r_zero;
   logic [WIDTH+1:0]     r_mag;
   logic                 w_last;

   cordic_atan_rom #(
      .ANGLE_W (ANGLE_W),
      .IDX_W   (CW)
   ) u_atan_rom (
      .i_idx  (r_iter),
      .o_atan (w_atan)
   );

   assign w_x_ext   = {{2{x_in[WIDTH-1]}}, x_in, {GUARD_BITS{1'b0}}};
   assign w_y_ext   = {{2{y_in[WIDTH-1]}}, y_in, {GUARD_BITS{1'b0}}};
   assign w_x_shr   = r_x >>> r_iter;
   assign w_y_shr   = r_y >>> r_iter;
   assign w_mag_rnd = r_x + HALF_LSB;
   assign w_last    = (r_iter == CW'(ITER));

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign mag_out   = r_mag;
   assign angle_out = r_angle;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic: accept in IDLE, iterate, hold result until taken
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_state_nxt = ST_ITER;
         ST_ITER: if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: pre-rotate on accept, micro-rotate, then register the result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_iter  <= '0;
         r_zero  <= 1'b0;
         r_mag   <= '0;
         r_angle <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_iter <= '0;
                  r_zero <= (x_in == '0) && (y_in == '0);
                  if (x_in[WIDTH-1]) begin
                     r_x <= -w_x_ext;
                     r_y <= -w_y_ext;
                     r_z <= ANG_HALF;
                  end else begin
                     r_x <= w_x_ext;
                     r_y <= w_y_ext;
                     r_z <= '0;
                  end
               end
            end
            ST_ITER: begin
               if (w_last) begin
                  r_mag   <= w_mag_rnd[GUARD_BITS +: WIDTH+2];
                  // The origin has no direction; report 0 instead of the
                  // sum of table entries the all-positive y path would give
                  r_angle <= r_zero ? '0 : r_z;
               end else begin
                  if (!r_y[DW-1]) begin
                     r_x <= r_x + w_y_shr;
                     r_y <= r_y - w_x_shr;
                     r_z <= r_z + w_atan;
                  end else begin
                     r_x <= r_x - w_y_shr;
                     r_y <= r_y + w_x_shr;
                     r_z <= r_z - w_atan;
                  end
                  r_iter <= r_iter + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
